// File: rtl/reg8_write_arbiter.sv
// Shared storage register with round-robin write arbitration.
// Requesters raise req with their data. The winner's data is captured, loaded into q,
// and the winner gets a one-cycle ack. At most one write completes every three cycles.
module reg8_write_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  localparam int unsigned GW     = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic [DATA_W-1:0]           q,
  output logic                        load,
  output logic [GW-1:0]               grant_id,
  output logic                        busy
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCapture = 2'd1;
  localparam logic [1:0] StWrite   = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [GW-1:0]       ptr_q, ptr_d;
  logic [GW-1:0]       grant_id_q, grant_id_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]   q_q, q_d;
  logic                load_q, load_d;
  logic                busy_q, busy_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;

  logic                found;
  logic [GW-1:0]       winner;
  logic [GW-1:0]       cand;
  int unsigned         scan_idx;

  // Round-robin search: first set req bit starting at ptr_q, wrapping.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand     = '0;
    scan_idx = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = (int'(ptr_q) + k) % NUM_REQ;
      cand     = GW'(scan_idx);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // FSM next-state and datapath next-state.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    hold_d     = hold_q;
    q_d        = q_q;
    load_d     = load_q;
    busy_d     = busy_q;
    ack_d      = ack_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_id_d = winner;
          hold_d     = req_data[int'(winner)*DATA_W +: DATA_W];
          busy_d     = 1'b1;
          state_d    = StCapture;
        end
      end
      StCapture: begin
        q_d     = hold_q;
        load_d  = 1'b1;
        ack_d   = NUM_REQ'(1) << grant_id_q;
        state_d = StWrite;
      end
      StWrite: begin
        ack_d   = '0;
        load_d  = 1'b0;
        busy_d  = 1'b0;
        // Move past the winner so a requester that keeps req high cannot starve others.
        ptr_d   = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset abandons any in-flight write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      grant_id_q <= '0;
      hold_q     <= '0;
      q_q        <= '0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      hold_q     <= hold_d;
      q_q        <= q_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
    end
  end

  assign ack      = ack_q;
  assign q        = q_q;
  assign load     = load_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule
